// File: rtl/spi_lcd_pkg.sv
// Shared constants and types for the LCD SPI receiver.
// Opcodes, reset values and the decoder state encoding.
package spi_lcd_pkg;

  localparam logic [7:0] CMD_SLPIN    = 8'h10;
  localparam logic [7:0] CMD_SLPOUT   = 8'h11;
  localparam logic [7:0] CMD_DISPOFF  = 8'h28;
  localparam logic [7:0] CMD_DISPON   = 8'h29;
  localparam logic [7:0] CMD_COLMOD   = 8'h3A;
  localparam logic [7:0] CMD_RAMWR    = 8'h2C;

  localparam logic [7:0] COLMOD_RESET = 8'h66;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_PARAM,
    ST_PIX_HI,
    ST_PIX_LO
  } dec_state_t;

endpackage

// File: rtl/spi_slave_rx.sv
// Oversampling SPI mode-0 byte deserializer.
// Synchronizes the link, detects scl/cs edges and assembles bytes.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       scl,
  input  logic       sda,
  input  logic       dc,
  output logic [7:0] byte_out,
  output logic       byte_dc,
  output logic       byte_valid,
  output logic       byte_abort
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic [SYNC_STAGES-1:0] dc_sync;

  logic       cs_s;
  logic       scl_s;
  logic       sda_s;
  logic       dc_s;
  logic       cs_prev;
  logic       scl_prev;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       scl_rise;
  logic       cs_rise;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign dc_s  = dc_sync[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_prev;
  assign cs_rise  = cs_s & ~cs_prev;

  // Bring the asynchronous link pins into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync  <= '1;
      scl_sync <= '0;
      sda_sync <= '0;
      dc_sync  <= '0;
      cs_prev  <= 1'b1;
      scl_prev <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      dc_sync  <= {dc_sync[SYNC_STAGES-2:0], dc};
      cs_prev  <= cs_s;
      scl_prev <= scl_s;
    end
  end

  // Shift bits on scl rises, emit whole bytes, abort partial ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift      <= '0;
      bit_cnt    <= '0;
      byte_out   <= '0;
      byte_dc    <= 1'b0;
      byte_valid <= 1'b0;
      byte_abort <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_abort <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
        if (cs_rise && bit_cnt != 3'd0) begin
          byte_abort <= 1'b1;
        end
      end else if (scl_rise) begin
        shift   <= {shift[6:0], sda_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_out   <= {shift[6:0], sda_s};
          byte_dc    <= dc_s;
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_lcd_rx.sv
// Display-side receiver for the 4-wire LCD SPI link.
// Decodes commands, parameters and RGB565 pixel writes.
module spi_lcd_rx
  import spi_lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PIXELS  = 76800,
  parameter int CNT_W       = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             scl,
  input  logic             sda,
  input  logic             dc,
  output logic [7:0]       byte_out,
  output logic             byte_dc,
  output logic             byte_valid,
  output logic             byte_abort,
  output logic             sleep_out,
  output logic             display_on,
  output logic [7:0]       colmod,
  output logic [15:0]      pixel,
  output logic             pixel_valid,
  output logic [CNT_W-1:0] pixel_count,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(MAX_PIXELS - 1);

  dec_state_t state;
  logic [7:0] pix_hi;

  spi_slave_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .scl       (scl),
    .sda       (sda),
    .dc        (dc),
    .byte_out  (byte_out),
    .byte_dc   (byte_dc),
    .byte_valid(byte_valid),
    .byte_abort(byte_abort)
  );

  // Decoder FSM: commands from any state, data by current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_CMD;
      pix_hi      <= '0;
      sleep_out   <= 1'b0;
      display_on  <= 1'b0;
      colmod      <= COLMOD_RESET;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      pixel_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (byte_valid) begin
        if (!byte_dc) begin
          state <= ST_CMD;
          unique case (byte_out)
            CMD_SLPOUT:  sleep_out  <= 1'b1;
            CMD_SLPIN:   sleep_out  <= 1'b0;
            CMD_DISPON:  display_on <= 1'b1;
            CMD_DISPOFF: display_on <= 1'b0;
            CMD_COLMOD:  state      <= ST_PARAM;
            CMD_RAMWR: begin
              pixel_count <= '0;
              state       <= ST_PIX_HI;
            end
            default: ;
          endcase
        end else begin
          unique case (state)
            ST_PARAM: begin
              colmod <= byte_out;
              state  <= ST_CMD;
            end
            ST_PIX_HI: begin
              pix_hi <= byte_out;
              state  <= ST_PIX_LO;
            end
            ST_PIX_LO: begin
              pixel       <= {pix_hi, byte_out};
              pixel_valid <= 1'b1;
              state       <= ST_PIX_HI;
              if (pixel_count == LAST_PIX) begin
                pixel_count <= '0;
                frame_done  <= 1'b1;
              end else begin
                pixel_count <= pixel_count + CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Self-checking bench for spi_lcd_rx with a small frame size.
// Directed table, corner sequences and random traffic vs a model.
module tb_spi_lcd_rx;

  localparam int SYNC = 2;
  localparam int MAXP = 4;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cs = 1'b1;
  logic          scl = 1'b0;
  logic          sda = 1'b0;
  logic          dc = 1'b0;
  logic [7:0]    byte_out;
  logic          byte_dc;
  logic          byte_valid;
  logic          byte_abort;
  logic          sleep_out;
  logic          display_on;
  logic [7:0]    colmod;
  logic [15:0]   pixel;
  logic          pixel_valid;
  logic [CW-1:0] pixel_count;
  logic          frame_done;

  spi_lcd_rx #(
    .SYNC_STAGES(SYNC),
    .MAX_PIXELS (MAXP),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .scl        (scl),
    .sda        (sda),
    .dc         (dc),
    .byte_out   (byte_out),
    .byte_dc    (byte_dc),
    .byte_valid (byte_valid),
    .byte_abort (byte_abort),
    .sleep_out  (sleep_out),
    .display_on (display_on),
    .colmod     (colmod),
    .pixel      (pixel),
    .pixel_valid(pixel_valid),
    .pixel_count(pixel_count),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state, expressed as the panel's rules
  logic       m_sleep;
  logic       m_disp;
  logic [7:0] m_colmod;
  int         m_cnt;
  bit         m_want_param;
  bit         m_in_ram;
  bit         m_have_hi;
  logic [7:0] m_hi;
  logic [15:0] m_last_px;

  typedef struct {
    logic [15:0] px;
    logic        fd;
  } pix_t;

  logic [8:0] exp_bytes[$];
  pix_t       exp_pix[$];
  int         n_sent = 0;
  int         n_bv = 0;
  int         n_ab = 0;
  int         n_pv = 0;
  int         n_fd = 0;

  task automatic model_reset();
    m_sleep = 1'b0;
    m_disp = 1'b0;
    m_colmod = 8'h66;
    m_cnt = 0;
    m_want_param = 0;
    m_in_ram = 0;
    m_have_hi = 0;
    m_hi = 8'h00;
    m_last_px = 16'h0000;
    exp_bytes.delete();
    exp_pix.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input logic d);
    pix_t p;
    exp_bytes.push_back({d, b});
    n_sent++;
    if (!d) begin
      m_have_hi = 0;
      m_want_param = (b == 8'h3A);
      m_in_ram = (b == 8'h2C);
      if (b == 8'h11) m_sleep = 1'b1;
      if (b == 8'h10) m_sleep = 1'b0;
      if (b == 8'h29) m_disp = 1'b1;
      if (b == 8'h28) m_disp = 1'b0;
      if (b == 8'h2C) m_cnt = 0;
    end else if (m_want_param) begin
      m_colmod = b;
      m_want_param = 0;
    end else if (m_in_ram) begin
      if (!m_have_hi) begin
        m_hi = b;
        m_have_hi = 1;
      end else begin
        m_have_hi = 0;
        m_cnt = (m_cnt + 1) % MAXP;
        p.px = {m_hi, b};
        p.fd = (m_cnt == 0);
        m_last_px = p.px;
        exp_pix.push_back(p);
      end
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic d,
                           input int nbits);
    if (cs) begin
      cs = 1'b0;
      wait_clk(2);
    end
    dc = d;
    for (int i = 7; i > 7 - nbits; i--) begin
      sda = b[i];
      wait_clk(3);
      scl = 1'b1;
      wait_clk(3);
      scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    model_byte(b, d);
    send_bits(b, d, 8);
    wait_clk(6);
  endtask

  task automatic cs_release();
    cs = 1'b1;
    wait_clk(6);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".sleep"}, 32'(sleep_out), 32'(m_sleep));
    chk({tag, ".disp"}, 32'(display_on), 32'(m_disp));
    chk({tag, ".colmod"}, 32'(colmod), 32'(m_colmod));
    chk({tag, ".count"}, 32'(pixel_count), 32'(m_cnt));
    chk({tag, ".pixel"}, 32'(pixel), 32'(m_last_px));
  endtask

  // Monitor: every output pulse must match an expected event
  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid) begin
        n_bv++;
        if (exp_bytes.size() == 0) begin
          chk("mon.unexpected_byte", 32'(byte_out), 32'h1ff);
        end else begin
          automatic logic [8:0] e = exp_bytes.pop_front();
          chk("mon.byte", 32'({byte_dc, byte_out}), 32'(e));
        end
      end
      if (byte_abort) n_ab++;
      if (frame_done) n_fd++;
      if (pixel_valid) begin
        n_pv++;
        if (exp_pix.size() == 0) begin
          chk("mon.unexpected_pixel", 32'(pixel), 32'h1ffff);
        end else begin
          automatic pix_t p = exp_pix.pop_front();
          chk("mon.pixel", 32'(pixel), 32'(p.px));
          chk("mon.frame_done", 32'(frame_done), 32'(p.fd));
        end
      end else if (frame_done) begin
        chk("mon.frame_done_alone", 32'(frame_done), 32'd0);
      end
    end
  end

  typedef struct {
    logic [7:0]  b;
    logic        d;
    logic        sl;
    logic        dn;
    logic [7:0]  cm;
    logic [2:0]  cnt;
    logic [15:0] px;
  } vec_t;

  vec_t tbl[9];

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".byte_out"}, 32'(byte_out), 32'h0);
    chk({tag, ".byte_dc"}, 32'(byte_dc), 32'h0);
    chk({tag, ".pulses"},
        32'({byte_valid, byte_abort, pixel_valid, frame_done}), 32'h0);
    chk({tag, ".sleep"}, 32'(sleep_out), 32'h0);
    chk({tag, ".disp"}, 32'(display_on), 32'h0);
    chk({tag, ".colmod"}, 32'(colmod), 32'h66);
    chk({tag, ".pixel"}, 32'(pixel), 32'h0);
    chk({tag, ".count"}, 32'(pixel_count), 32'h0);
  endtask

  initial begin
    int ab0;
    int bv0;
    int pv0;
    tbl[0] = '{8'h11, 1'b0, 1'b1, 1'b0, 8'h66, 3'd0, 16'h0000};
    tbl[1] = '{8'h29, 1'b0, 1'b1, 1'b1, 8'h66, 3'd0, 16'h0000};
    tbl[2] = '{8'h3A, 1'b0, 1'b1, 1'b1, 8'h66, 3'd0, 16'h0000};
    tbl[3] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 3'd0, 16'h0000};
    tbl[4] = '{8'h2C, 1'b0, 1'b1, 1'b1, 8'h55, 3'd0, 16'h0000};
    tbl[5] = '{8'hF8, 1'b1, 1'b1, 1'b1, 8'h55, 3'd0, 16'h0000};
    tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 3'd1, 16'hF800};
    tbl[7] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h55, 3'd1, 16'hF800};
    tbl[8] = '{8'hE0, 1'b1, 1'b1, 1'b1, 8'h55, 3'd2, 16'h07E0};

    model_reset();
    wait_clk(4);
    chk_reset_vals("reset");
    reset = 1'b0;
    wait_clk(4);

    // Init sequence and first pixel writes from the table
    for (int i = 0; i < 9; i++) begin
      send_byte(tbl[i].b, tbl[i].d);
      chk($sformatf("tbl%0d.sleep", i), 32'(sleep_out), 32'(tbl[i].sl));
      chk($sformatf("tbl%0d.disp", i), 32'(display_on), 32'(tbl[i].dn));
      chk($sformatf("tbl%0d.colmod", i), 32'(colmod), 32'(tbl[i].cm));
      chk($sformatf("tbl%0d.count", i), 32'(pixel_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.pixel", i), 32'(pixel), 32'(tbl[i].px));
    end
    chk("init.byte_valid_count", 32'(n_bv), 32'd9);
    chk("init.pixel_valid_count", 32'(n_pv), 32'd2);
    cs_release();

    // Partial byte then cs rise: one abort, no byte
    ab0 = n_ab;
    bv0 = n_bv;
    send_bits(8'hAB, 1'b0, 5);
    cs_release();
    chk("abort.count", 32'(n_ab - ab0), 32'd1);
    chk("abort.no_byte", 32'(n_bv - bv0), 32'd0);
    send_byte(8'h28, 1'b0);
    send_byte(8'h29, 1'b0);
    chk("abort.next_byte", 32'(display_on), 32'd1);
    chk("abort.byte_out", 32'(byte_out), 32'h29);
    cs_release();

    // Command interrupts a half pixel
    pv0 = n_pv;
    send_byte(8'h2C, 1'b0);
    send_byte(8'h1F, 1'b1);
    send_byte(8'h28, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    chk("drop.no_pixel", 32'(n_pv - pv0), 32'd0);
    chk("drop.disp", 32'(display_on), 32'd0);
    chk("drop.count", 32'(pixel_count), 32'd0);

    // Frame wrap at MAXP pixels
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < MAXP; i++) begin
      send_byte(8'(8'h10 + i), 1'b1);
      send_byte(8'(8'hA0 + i), 1'b1);
    end
    chk("wrap.count", 32'(pixel_count), 32'd0);
    chk("wrap.frame_done", 32'(n_fd), 32'd1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    chk("wrap.fifth_count", 32'(pixel_count), 32'd1);
    chk("wrap.fifth_pixel", 32'(pixel), 32'h1234);
    cs_release();

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      logic d;
      case ($urandom_range(0, 9))
        0: b = 8'h10;
        1: b = 8'h11;
        2: b = 8'h28;
        3: b = 8'h29;
        4: b = 8'h3A;
        5: b = 8'h2C;
        default: b = 8'($urandom);
      endcase
      d = ($urandom_range(0, 2) != 0);
      send_byte(b, d);
      if ($urandom_range(0, 4) == 0) cs_release();
      if (i % 6 == 5) chk_model($sformatf("rnd%0d", i));
    end
    chk_model("rnd.end");
    cs_release();

    // Asynchronous reset mid-pixel after an init sequence
    send_byte(8'h11, 1'b0);
    send_byte(8'h29, 1'b0);
    send_byte(8'h3A, 1'b0);
    send_byte(8'h77, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_byte(8'hAA, 1'b1);
    send_bits(8'hC3, 1'b1, 3);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("arst");
    model_reset();
    cs = 1'b1;
    scl = 1'b0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(4);
    chk("arst.no_abort_byte", 32'(byte_valid | byte_abort), 32'd0);
    pv0 = n_pv;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    chk("arst.cmd_state", 32'(n_pv - pv0), 32'd0);
    chk("arst.colmod", 32'(colmod), 32'h66);
    send_byte(8'h29, 1'b0);
    chk("arst.disp", 32'(display_on), 32'd1);
    cs_release();

    chk("end.byte_queue", 32'(exp_bytes.size()), 32'd0);
    chk("end.pixel_queue", 32'(exp_pix.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_lcd_rx.md
# spi_lcd_rx

Display-side receiver for the 4-wire LCD SPI link (cs, scl, sda, dc) driven by the team's SPI display controller. It oversamples the link in the `clk` domain and deserializes bytes. It then decodes the command/parameter/pixel stream into panel state and RGB565 pixel writes. It serves as the bench-side display model for controller verification and as the front end of an on-FPGA framebuffer.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for cs/scl/sda/dc (≥2).
- MAX_PIXELS, 76800, pixels per frame (240×320); pixel counter wraps here.
- CNT_W, 17, pixel_count width; must satisfy 2^CNT_W > MAX_PIXELS.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  chip select, active low, asynchronous to clk.
- scl  in  1  SPI clock, mode 0, frequency ≤ clk/4.
- sda  in  1  serial data, MSB first.
- dc  in  1  0 = command byte, 1 = data/parameter byte.
- byte_out  out  8  last received byte.
- byte_dc  out  1  dc value captured with byte_out.
- byte_valid  out  1  one-cycle pulse per complete byte.
- byte_abort  out  1  one-cycle pulse when cs rises with 1–7 bits received.
- sleep_out  out  1  panel awake flag.
- display_on  out  1  display enable flag.
- colmod  out  8  last COLMOD parameter.
- pixel  out  16  assembled RGB565 pixel {hi, lo}.
- pixel_valid  out  1  one-cycle pulse per pixel.
- pixel_count  out  CNT_W  pixels written since last 0x2C.
- frame_done  out  1  one-cycle pulse when pixel_count wraps.

## Operation
- Reset values: byte_out=0, byte_dc=0, all pulses=0, sleep_out=0, display_on=0, colmod=8'h66, pixel=0, pixel_count=0, decoder state=CMD.
- Deserializer: operates on synchronized signals. A rising edge of synced scl while synced cs=0 shifts sda into an 8-bit register and increments a 3-bit counter. On the 8th edge, byte_out and byte_dc are loaded, with dc sampled on that same edge, and byte_valid pulses.
- Synced cs high clears the bit counter. If the counter is nonzero when cs rises, byte_abort pulses and the partial byte is discarded. Bytes may span multiple cs-low windows only when they are whole bytes.
- Decoder FSM states are CMD, PARAM, PIX_HI and PIX_LO. It acts only on byte_valid.
- Any dc=0 byte is a command and is decoded from any state. A half-assembled pixel is dropped.
  - 0x11: sleep_out=1, next CMD.
  - 0x10: sleep_out=0, next CMD.
  - 0x29: display_on=1, next CMD.
  - 0x28: display_on=0, next CMD.
  - 0x3A: next PARAM.
  - 0x2C: pixel_count=0, next PIX_HI.
  - Other opcodes: next CMD, no effect.
- Data bytes (dc=1):
  - In PARAM: colmod=byte, next CMD.
  - In PIX_HI: latch the high byte, next PIX_LO.
  - In PIX_LO: pixel={hi, byte}, pixel_valid pulses, pixel_count increments, next PIX_HI.
  - In CMD: ignored.
- Wrap: if the increment would reach MAX_PIXELS, pixel_count=0 and frame_done pulses in the same cycle as pixel_valid. The FSM stays in PIX_HI.
- Reset mid-byte or mid-pixel returns everything to reset values immediately.

## Timing
- byte_valid rises SYNC_STAGES+1 clk cycles after the 8th scl rising edge at the pin.
- Decoder outputs (flags, colmod, pixel, pixel_valid, pixel_count, frame_done) update 1 cycle after byte_valid. Total latency from the 8th scl edge is SYNC_STAGES+2.
- byte_abort fires SYNC_STAGES+1 cycles after the cs rising edge.
- scl high and low phases must each last ≥2 clk. Faster scl is out of spec and is not detected.
- byte_valid is at most 1 per 8 scl periods, so there is no backpressure and no buffering.

## Structure
- Package spi_lcd_pkg holds:
  - Opcode constants: CMD_SLPIN 8'h10, CMD_SLPOUT 8'h11, CMD_DISPOFF 8'h28, CMD_DISPON 8'h29, CMD_COLMOD 8'h3A, CMD_RAMWR 8'h2C.
  - COLMOD_RESET 8'h66.
  - The decoder state enum.
- Sub-module spi_slave_rx contains the synchronizers, edge detection, shift register and bit counter, and drives byte_out, byte_dc, byte_valid and byte_abort.
- The top level holds the decoder FSM and pixel counter.

## Test plan
- Init sequence 0x11, 0x29, 0x3A (dc=0), then 0x55 (dc=1) -> sleep_out=1, display_on=1, colmod=8'h55, 4 byte_valid pulses.
- 0x2C, then data 0xF8, 0x00, 0x07, 0xE0 -> pixel_valid ×2 with pixel=16'hF800 then 16'h07E0, pixel_count=2.
- cs rises after 5 bits of 0xAB -> byte_abort pulses once, no byte_valid; the next full byte 0x29 decodes correctly.
- 0x2C, data 0x1F, then command 0x28 before the low byte -> no pixel_valid, display_on=0, state CMD.
- MAX_PIXELS=4: 0x2C, then 4 pixels -> frame_done coincides with the 4th pixel_valid, pixel_count=0; a 5th pixel gives pixel_count=1.
- Assert reset mid-pixel after an init sequence -> all outputs return to reset values, colmod=8'h66, and the next byte decodes from CMD.
